state_register_ctrl: RTL and testbench
======================================

# state_register_ctrl

Parametrised state register for the flasher control path. Holds the current FSM state, clocked by the divided clock, and adds several features: load enable, synchronous force-load, illegal-code recovery, previous-state capture, a state-change strobe and a per-state dwell counter. It sits between the next-state logic and the output decoder. It is the drop-in generalisation of the plain 3-bit state register.

## Interface
Parameters:
- ST_W, 3: state code width in bits, ≥1.
- ST_INITIAL, 0: reset and recovery state code.
- ST_MAX, 5: highest legal state code; codes above it are illegal. Must satisfy ST_INITIAL ≤ ST_MAX ≤ 2^ST_W−1.
- DWELL_W, 8: dwell counter width in bits, ≥2.

Ports:
- div_clk, in, 1: divided clock; all state changes on its rising edge.
- rst, in, 1: asynchronous, active-high reset.
- en, in, 1: when high, nxt_st is sampled this cycle.
- nxt_st, in, ST_W: next state from the next-state logic.
- force_vld, in, 1: synchronous force-load request.
- force_st, in, ST_W: state to force.
- err_clr, in, 1: clears err_sticky.
- cur_st, out, ST_W: current state.
- prv_st, out, ST_W: state held before the most recent change.
- st_chg, out, 1: one-cycle strobe, high in the first cycle of a new cur_st value.
- dwell_cnt, out, DWELL_W: cycles spent in cur_st since entry, saturating.
- err, out, 1: one-cycle pulse flagging an illegal code rejected on the last edge.
- err_sticky, out, 1: latched illegal-code flag.

## Operation
- All outputs are registered.
- Reset values: cur_st = prv_st = ST_INITIAL; st_chg = 0; dwell_cnt = 0; err = 0; err_sticky = 0.
- Candidate selection on each div_clk edge, in priority order:
  1. force_vld: cand = force_st.
  2. en: cand = nxt_st.
  3. Otherwise: hold (no load).
- Legality check: if a load occurs and cand > ST_MAX, the register loads ST_INITIAL and err pulses for 1 cycle. This applies to force_st as well as nxt_st.
- Change detection: change = (loaded value ≠ cur_st).
- On change:
  - prv_st ← old cur_st.
  - st_chg ← 1.
  - dwell_cnt ← 0.
- With no change, including a hold or a reload of the same code:
  - st_chg ← 0.
  - prv_st holds.
  - dwell_cnt increments, saturating at 2^DWELL_W−1.
- Exception: a legal force_vld load restarts dwell_cnt at 0 even when the code is unchanged. st_chg stays 0 in that case.
- err_sticky:
  - Set by any err event.
  - Cleared by err_clr.
  - If both occur in the same cycle, set wins.
- An illegal code is never visible on cur_st.

## Timing
- Latency: inputs sampled at edge N appear on cur_st, prv_st, st_chg, dwell_cnt and err after edge N (1 cycle).
- No handshake; en and force_vld are level-sampled every edge. There is no backpressure.
- st_chg and err are single-cycle unless the triggering condition repeats on consecutive edges.
- Reset asserted mid-operation: all outputs return to their reset values immediately, without waiting for div_clk.
- First edge after rst deasserts: normal operation; dwell_cnt counts from 0.
- Dwell counter: saturates, never wraps. A change at saturation restarts it at 0.

## Configuration
- STATE_REG_DWELL_EN:
  - Defined: the dwell counter is implemented as described above.
  - Undefined: the counter logic is removed and dwell_cnt is tied to 0. All other behaviour is unchanged.

## Test plan
- Reset: assert rst asynchronously mid-cycle while cur_st = 4 → cur_st = 0, prv_st = 0, dwell_cnt = 0 and err_sticky = 0 without a div_clk edge.
- Normal load (ST_W=3, ST_MAX=5): en = 1 with nxt_st = 2, then 3 → cur_st = 2 then 3; prv_st = 0 then 2; st_chg high for 1 cycle each; dwell_cnt = 0 on entry to each state.
- Hold and saturation (DWELL_W=3): en = 0 for 10 cycles → dwell_cnt = 1..7, then stays 7; st_chg = 0 throughout.
- Illegal code: en = 1, nxt_st = 6 while cur_st = 3 → cur_st = 0, prv_st = 3, err pulses 1 cycle, err_sticky = 1. Then err_clr and a second illegal code in the same cycle → err_sticky stays 1.
- Force priority: force_vld = 1, force_st = 5 with en = 1, nxt_st = 1 → cur_st = 5. Then force_st = 5 again → st_chg = 0 and dwell_cnt = 0.
- Macro off: build without STATE_REG_DWELL_EN and repeat the hold test → dwell_cnt = 0 throughout; all other outputs identical to the macro-on build.

Source files
------------

// File: rtl/state_register_ctrl_if.sv
// Port bundle for state_register_ctrl: next-state/force/clear inputs and the registered state outputs.
interface state_register_ctrl_if #(
  parameter int ST_W    = 3,
  parameter int DWELL_W = 8
);
  logic               en;
  logic [ST_W-1:0]    nxt_st;
  logic               force_vld;
  logic [ST_W-1:0]    force_st;
  logic               err_clr;
  logic [ST_W-1:0]    cur_st;
  logic [ST_W-1:0]    prv_st;
  logic               st_chg;
  logic [DWELL_W-1:0] dwell_cnt;
  logic               err;
  logic               err_sticky;

  modport master (
    output en, nxt_st, force_vld, force_st, err_clr,
    input  cur_st, prv_st, st_chg, dwell_cnt, err, err_sticky
  );

  modport slave (
    input  en, nxt_st, force_vld, force_st, err_clr,
    output cur_st, prv_st, st_chg, dwell_cnt, err, err_sticky
  );
endinterface

// File: rtl/state_register_ctrl.sv
// Flasher state register with force-load, illegal-code recovery, change strobe and dwell counter.
// Define STATE_REG_DWELL_EN to build the dwell counter; otherwise dwell_cnt is tied to zero.
module state_register_ctrl #(
  parameter int ST_W       = 3,
  parameter int ST_INITIAL = 0,
  parameter int ST_MAX     = 5,
  parameter int DWELL_W    = 8
) (
  input logic                 div_clk,
  input logic                 rst,
  state_register_ctrl_if.slave bus
);

  localparam logic [ST_W-1:0] ST_INIT_C = ST_W'(ST_INITIAL);
  localparam logic [ST_W-1:0] ST_MAX_C  = ST_W'(ST_MAX);

  logic [ST_W-1:0] cur_q, cur_d;
  logic [ST_W-1:0] prv_q, prv_d;
  logic [ST_W-1:0] cand_s;
  logic            chg_q, chg_d;
  logic            err_q, err_d;
  logic            sticky_q, sticky_d;
  logic            load_s;
  logic            illegal_s;

  // Candidate selection, legality check and change detection
  always_comb begin
    cand_s = cur_q;
    load_s = 1'b0;
    if (bus.force_vld) begin
      cand_s = bus.force_st;
      load_s = 1'b1;
    end else if (bus.en) begin
      cand_s = bus.nxt_st;
      load_s = 1'b1;
    end else begin
      cand_s = cur_q;
      load_s = 1'b0;
    end

    illegal_s = load_s && (cand_s > ST_MAX_C);

    if (illegal_s) begin
      cur_d = ST_INIT_C;
    end else if (load_s) begin
      cur_d = cand_s;
    end else begin
      cur_d = cur_q;
    end

    chg_d = (cur_d != cur_q);
    if (chg_d) begin
      prv_d = cur_q;
    end else begin
      prv_d = prv_q;
    end

    err_d = illegal_s;
    // A new error outranks a same-cycle clear
    if (illegal_s) begin
      sticky_d = 1'b1;
    end else if (bus.err_clr) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end
  end

  // State, history and error flag registers
  always_ff @(posedge div_clk or posedge rst) begin
    if (rst) begin
      cur_q    <= ST_INIT_C;
      prv_q    <= ST_INIT_C;
      chg_q    <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      cur_q    <= cur_d;
      prv_q    <= prv_d;
      chg_q    <= chg_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
    end
  end

`ifdef STATE_REG_DWELL_EN
  localparam logic [DWELL_W-1:0] DWELL_MAX = {DWELL_W{1'b1}};

  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               restart_s;

  // A legal force restarts the dwell count even when the code is unchanged
  always_comb begin
    restart_s = chg_d | (bus.force_vld & ~illegal_s);
    if (restart_s) begin
      dwell_d = {DWELL_W{1'b0}};
    end else if (dwell_q == DWELL_MAX) begin
      dwell_d = dwell_q;
    end else begin
      dwell_d = dwell_q + DWELL_W'(1);
    end
  end

  // Dwell counter register
  always_ff @(posedge div_clk or posedge rst) begin
    if (rst) begin
      dwell_q <= {DWELL_W{1'b0}};
    end else begin
      dwell_q <= dwell_d;
    end
  end

  assign bus.dwell_cnt = dwell_q;
`else
  assign bus.dwell_cnt = {DWELL_W{1'b0}};
`endif

  assign bus.cur_st     = cur_q;
  assign bus.prv_st     = prv_q;
  assign bus.st_chg     = chg_q;
  assign bus.err        = err_q;
  assign bus.err_sticky = sticky_q;

endmodule

// File: tb/tb_state_register_ctrl.sv
// Scoreboard bench for state_register_ctrl (ST_W=3, ST_MAX=5, DWELL_W=3) with directed vectors.
module tb_state_register_ctrl;

  localparam int ST_W    = 3;
  localparam int DWELL_W = 3;

  typedef struct {
    int idx;
    int cur;
    int prv;
    int chg;
    int dwell;
    int err;
    int sticky;
  } exp_t;

  logic div_clk = 1'b0;
  logic rst     = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   pushed   = 0;
  int   popped   = 0;
  int   vec_no   = 0;
  exp_t exp_q[$];

  state_register_ctrl_if #(.ST_W(ST_W), .DWELL_W(DWELL_W)) bus ();

  state_register_ctrl #(
    .ST_W(ST_W), .ST_INITIAL(0), .ST_MAX(5), .DWELL_W(DWELL_W)
  ) dut (
    .div_clk(div_clk),
    .rst    (rst),
    .bus    (bus.slave)
  );

  always #5 div_clk = ~div_clk;

  task automatic chk(input string nm, input int idx, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL vec%0d %s got=%0d expected=%0d", idx, nm, got, want);
    end
  endtask

  task automatic push_exp(input int cur, input int prv, input int chg, input int dw,
                          input int er, input int st);
    exp_t e;
    e.idx = vec_no; e.cur = cur; e.prv = prv; e.chg = chg;
    e.dwell = dw; e.err = er; e.sticky = st;
    exp_q.push_back(e);
    pushed++;
    vec_no++;
  endtask

  // Drive one edge's inputs, record the hand-computed response, then clock it in
  task automatic vec(input logic en, input int nxt, input logic fv, input int fs, input logic clr,
                     input int cur, input int prv, input int chg, input int dw,
                     input int er, input int st);
    bus.en        = en;
    bus.nxt_st    = ST_W'(nxt);
    bus.force_vld = fv;
    bus.force_st  = ST_W'(fs);
    bus.err_clr   = clr;
    push_exp(cur, prv, chg, dw, er, st);
    @(posedge div_clk);
    #2;
  endtask

  // Monitor: compare after every clock edge or asynchronous reset assertion
  initial begin
    exp_t e;
    int   dw_exp;
    forever begin
      @(posedge div_clk or posedge rst);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        popped++;
`ifdef STATE_REG_DWELL_EN
        dw_exp = e.dwell;
`else
        dw_exp = 0;
`endif
        chk("cur_st",     e.idx, int'(bus.cur_st),     e.cur);
        chk("prv_st",     e.idx, int'(bus.prv_st),     e.prv);
        chk("st_chg",     e.idx, int'(bus.st_chg),     e.chg);
        chk("dwell_cnt",  e.idx, int'(bus.dwell_cnt),  dw_exp);
        chk("err",        e.idx, int'(bus.err),        e.err);
        chk("err_sticky", e.idx, int'(bus.err_sticky), e.sticky);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.en = 1'b0; bus.nxt_st = '0; bus.force_vld = 1'b0; bus.force_st = '0; bus.err_clr = 1'b0;
    #23 rst = 1'b0;
    @(posedge div_clk);
    #2;

    //   en nxt fv fs clr | cur prv chg dw err st
    vec(1'b1, 2, 1'b0, 0, 1'b0,   2, 0, 1, 0, 0, 0);
    vec(1'b1, 3, 1'b0, 0, 1'b0,   3, 2, 1, 0, 0, 0);
    for (int i = 1; i <= 10; i++)
      vec(1'b0, 0, 1'b0, 0, 1'b0, 3, 2, 0, (i > 7) ? 7 : i, 0, 0);
    vec(1'b1, 3, 1'b0, 0, 1'b0,   3, 2, 0, 7, 0, 0);
    vec(1'b1, 6, 1'b0, 0, 1'b0,   0, 3, 1, 0, 1, 1);
    vec(1'b0, 0, 1'b0, 0, 1'b0,   0, 3, 0, 1, 0, 1);
    vec(1'b1, 7, 1'b0, 0, 1'b1,   0, 3, 0, 2, 1, 1);
    vec(1'b0, 0, 1'b0, 0, 1'b1,   0, 3, 0, 3, 0, 0);
    vec(1'b1, 1, 1'b1, 5, 1'b0,   5, 0, 1, 0, 0, 0);
    vec(1'b0, 0, 1'b0, 0, 1'b0,   5, 0, 0, 1, 0, 0);
    vec(1'b0, 0, 1'b0, 0, 1'b0,   5, 0, 0, 2, 0, 0);
    vec(1'b0, 0, 1'b1, 5, 1'b0,   5, 0, 0, 0, 0, 0);
    vec(1'b0, 0, 1'b1, 7, 1'b0,   0, 5, 1, 0, 1, 1);
    vec(1'b1, 4, 1'b0, 0, 1'b0,   4, 0, 1, 0, 0, 1);
    vec(1'b0, 0, 1'b0, 0, 1'b0,   4, 0, 0, 1, 0, 1);

    // Asynchronous reset mid-cycle while cur_st = 4
    push_exp(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(posedge div_clk);
    #3 rst = 1'b0;

    vec(1'b0, 0, 1'b0, 0, 1'b0,   0, 0, 0, 1, 0, 0);
    vec(1'b1, 1, 1'b0, 0, 1'b0,   1, 0, 1, 0, 0, 0);
    vec(1'b1, 5, 1'b0, 0, 1'b0,   5, 1, 1, 0, 0, 0);

    #10;
    checks++;
    if (popped != pushed) begin
      failures++;
      $display("FAIL scoreboard_drain popped=%0d pushed=%0d", popped, pushed);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
